// File: rtl/pc_pkg.sv
// Shared constants and types for the PC source selector and PC register.
package pc_pkg;

  localparam int PCS_INC    = 0;
  localparam int PCS_BRANCH = 1;
  localparam int PCS_JUMP   = 2;
  localparam int PCS_JR     = 3;
  localparam int PCS_EPC    = 4;

  typedef logic [31:0] word_t;

  localparam word_t PC_RESET_VEC = 32'h0000_0000;
  localparam word_t PC_EXC_VEC   = 32'h0000_00FF;

endpackage

// File: rtl/pc_src_sel.sv
// Combinational PC source multiplexer; flags select codes with no source behind them.
module pc_src_sel #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 5,
  parameter int SEL_W   = 3
) (
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] src,
  output logic [WIDTH-1:0]         raw,
  output logic                     bad_sel
);

  always_comb begin
    raw     = '0;
    bad_sel = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        raw     = src[k*WIDTH +: WIDTH];
        bad_sel = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_source_reg.sv
// PC register with source select, branch-conditional load, previous-PC capture
// and redirect to an exception vector on illegal select or misaligned target.
module pc_source_reg
  import pc_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               NUM_SRC     = 5,
  parameter int               SEL_W       = 3,
  parameter logic [WIDTH-1:0] RESET_VEC   = WIDTH'(PC_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC     = WIDTH'(PC_EXC_VEC),
  parameter bit               ALIGN_CHECK = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] src,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     cond,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         next_pc,
  output logic [WIDTH-1:0]         pc_q,
  output logic [WIDTH-1:0]         pc_prev,
  output logic                     update,
  output logic                     sel_err,
  output logic                     align_err
);

  logic [WIDTH-1:0] raw;
  logic             bad_sel;
  logic             bad_align;
  logic             load;

  pc_src_sel #(
    .WIDTH  (WIDTH),
    .NUM_SRC(NUM_SRC),
    .SEL_W  (SEL_W)
  ) u_sel (
    .sel    (sel),
    .src    (src),
    .raw    (raw),
    .bad_sel(bad_sel)
  );

  // Alignment is only meaningful for a real source, so the two faults never coexist.
  assign bad_align = ALIGN_CHECK && !bad_sel && (raw[1:0] != 2'b00);
  assign next_pc   = (bad_sel || bad_align) ? EXC_VEC : raw;
  assign load      = pc_write | (pc_write_cond & cond);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_VEC;
      pc_prev   <= RESET_VEC;
      update    <= 1'b0;
      sel_err   <= 1'b0;
      align_err <= 1'b0;
    end else begin
      update <= load;
      if (load) begin
        pc_q    <= next_pc;
        pc_prev <= pc_q;
      end
      // A fault reported on this load outranks a simultaneous clear.
      sel_err   <= (load & bad_sel)   | (sel_err   & ~err_clr);
      align_err <= (load & bad_align) | (align_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_pc_source_reg.sv
// Directed bench for pc_source_reg: a checking instance plus an ALIGN_CHECK = 0 twin.
module tb_pc_source_reg;

  localparam int W = 32;
  localparam int N = 5;
  localparam int S = 3;

  logic         clk;
  logic         reset_n;
  logic [S-1:0] sel;
  logic [N*W-1:0] src;
  logic         pc_write;
  logic         pc_write_cond;
  logic         cond;
  logic         err_clr;

  logic [W-1:0] next_pc, pc_q, pc_prev;
  logic         update, sel_err, align_err;
  logic [W-1:0] na_next_pc, na_pc_q, na_pc_prev;
  logic         na_update, na_sel_err, na_align_err;

  int checks = 0;
  int errors = 0;

  pc_source_reg #(
    .WIDTH(W), .NUM_SRC(N), .SEL_W(S),
    .RESET_VEC(32'h0), .EXC_VEC(32'hFF), .ALIGN_CHECK(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .src(src),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond(cond),
    .err_clr(err_clr), .next_pc(next_pc), .pc_q(pc_q), .pc_prev(pc_prev),
    .update(update), .sel_err(sel_err), .align_err(align_err)
  );

  pc_source_reg #(
    .WIDTH(W), .NUM_SRC(N), .SEL_W(S),
    .RESET_VEC(32'h0), .EXC_VEC(32'hFF), .ALIGN_CHECK(1'b0)
  ) dut_na (
    .clk(clk), .reset_n(reset_n), .sel(sel), .src(src),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond(cond),
    .err_clr(err_clr), .next_pc(na_next_pc), .pc_q(na_pc_q), .pc_prev(na_pc_prev),
    .update(na_update), .sel_err(na_sel_err), .align_err(na_align_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    cond          = 1'b0;
    err_clr       = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    sel     = '0;
    src     = '0;
    idle();
    #12;
    checks++; if (pc_q !== 32'h0) begin errors++; $display("FAIL reset_pc_q got %h exp %h", pc_q, 32'h0); end
    checks++; if (pc_prev !== 32'h0) begin errors++; $display("FAIL reset_pc_prev got %h exp %h", pc_prev, 32'h0); end
    checks++; if ({update, sel_err, align_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {update, sel_err, align_err}); end
    reset_n = 1'b1;
  endtask

  task automatic test_inc;
    sel = 3'd0;
    src[0*W +: W] = 32'h4;
    pc_write = 1'b1;
    #1;
    checks++; if (next_pc !== 32'h4) begin errors++; $display("FAIL inc_next_pc got %h exp %h", next_pc, 32'h4); end
    step();
    idle();
    checks++; if (pc_q !== 32'h4) begin errors++; $display("FAIL inc_pc_q got %h exp %h", pc_q, 32'h4); end
    checks++; if (pc_prev !== 32'h0) begin errors++; $display("FAIL inc_pc_prev got %h exp %h", pc_prev, 32'h0); end
    checks++; if (update !== 1'b1) begin errors++; $display("FAIL inc_update got %b exp 1", update); end
    checks++; if ({sel_err, align_err} !== 2'b00) begin errors++; $display("FAIL inc_flags got %b exp 00", {sel_err, align_err}); end
    step();
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL inc_update_drop got %b exp 0", update); end
    checks++; if (pc_q !== 32'h4) begin errors++; $display("FAIL inc_hold got %h exp %h", pc_q, 32'h4); end
  endtask

  task automatic test_branch;
    sel = 3'd1;
    src[1*W +: W] = 32'h40;
    pc_write_cond = 1'b1;
    cond = 1'b0;
    step();
    checks++; if (pc_q !== 32'h4) begin errors++; $display("FAIL br_not_taken_pc got %h exp %h", pc_q, 32'h4); end
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL br_not_taken_update got %b exp 0", update); end
    cond = 1'b1;
    step();
    idle();
    checks++; if (pc_q !== 32'h40) begin errors++; $display("FAIL br_taken_pc got %h exp %h", pc_q, 32'h40); end
    checks++; if (pc_prev !== 32'h4) begin errors++; $display("FAIL br_taken_prev got %h exp %h", pc_prev, 32'h4); end
    checks++; if (update !== 1'b1) begin errors++; $display("FAIL br_taken_update got %b exp 1", update); end
    // pc_write must load even with a false branch condition
    sel = 3'd2;
    src[2*W +: W] = 32'h80;
    pc_write = 1'b1;
    pc_write_cond = 1'b1;
    cond = 1'b0;
    step();
    idle();
    checks++; if (pc_q !== 32'h80) begin errors++; $display("FAIL write_dominates got %h exp %h", pc_q, 32'h80); end
  endtask

  task automatic test_back_to_back;
    sel = 3'd0;
    src[0*W +: W] = 32'h44;
    pc_write = 1'b1;
    step();
    checks++; if (update !== 1'b1) begin errors++; $display("FAIL b2b_update1 got %b exp 1", update); end
    src[0*W +: W] = 32'h48;
    step();
    idle();
    checks++; if (update !== 1'b1) begin errors++; $display("FAIL b2b_update2 got %b exp 1", update); end
    checks++; if (pc_q !== 32'h48) begin errors++; $display("FAIL b2b_pc_q got %h exp %h", pc_q, 32'h48); end
    checks++; if (pc_prev !== 32'h44) begin errors++; $display("FAIL b2b_pc_prev got %h exp %h", pc_prev, 32'h44); end
  endtask

  task automatic test_illegal_sel;
    sel = 3'd6;
    #1;
    checks++; if (next_pc !== 32'hFF) begin errors++; $display("FAIL ill_next_pc got %h exp %h", next_pc, 32'hFF); end
    step();
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL ill_no_load_flag got %b exp 0", sel_err); end
    checks++; if (pc_q !== 32'h48) begin errors++; $display("FAIL ill_no_load_pc got %h exp %h", pc_q, 32'h48); end
    pc_write = 1'b1;
    step();
    checks++; if (pc_q !== 32'hFF) begin errors++; $display("FAIL ill_pc_q got %h exp %h", pc_q, 32'hFF); end
    checks++; if ({sel_err, align_err} !== 2'b10) begin errors++; $display("FAIL ill_flags got %b exp 10", {sel_err, align_err}); end
    sel = 3'd0;
    src[0*W +: W] = 32'h8;
    step();
    idle();
    checks++; if (pc_q !== 32'h8) begin errors++; $display("FAIL ill_next_load got %h exp %h", pc_q, 32'h8); end
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL ill_sticky got %b exp 1", sel_err); end
  endtask

  task automatic test_flag_clear;
    err_clr = 1'b1;
    step();
    idle();
    checks++; if ({sel_err, align_err} !== 2'b00) begin errors++; $display("FAIL clr_flags got %b exp 00", {sel_err, align_err}); end
    // misaligned target, compared against the twin with alignment checking off
    sel = 3'd3;
    src[3*W +: W] = 32'h1002;
    pc_write = 1'b1;
    #1;
    checks++; if (next_pc !== 32'hFF) begin errors++; $display("FAIL mis_next_pc got %h exp %h", next_pc, 32'hFF); end
    step();
    idle();
    checks++; if (pc_q !== 32'hFF) begin errors++; $display("FAIL mis_pc_q got %h exp %h", pc_q, 32'hFF); end
    checks++; if ({sel_err, align_err} !== 2'b01) begin errors++; $display("FAIL mis_flags got %b exp 01", {sel_err, align_err}); end
    checks++; if (na_pc_q !== 32'h1002) begin errors++; $display("FAIL noalign_pc_q got %h exp %h", na_pc_q, 32'h1002); end
    checks++; if (na_align_err !== 1'b0) begin errors++; $display("FAIL noalign_flag got %b exp 0", na_align_err); end
    // set and clear in the same cycle: set wins, the other flag still clears
    sel = 3'd7;
    pc_write = 1'b1;
    err_clr = 1'b1;
    step();
    idle();
    checks++; if ({sel_err, align_err} !== 2'b10) begin errors++; $display("FAIL set_vs_clr got %b exp 10", {sel_err, align_err}); end
    checks++; if (pc_q !== 32'hFF) begin errors++; $display("FAIL set_vs_clr_pc got %h exp %h", pc_q, 32'hFF); end
  endtask

  task automatic test_async_reset;
    sel = 3'd1;
    src[1*W +: W] = 32'h40;
    pc_write = 1'b1;
    step();
    checks++; if (pc_q !== 32'h40) begin errors++; $display("FAIL ar_pre_pc got %h exp %h", pc_q, 32'h40); end
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL ar_pre_flag got %b exp 1", sel_err); end
    sel = 3'd6;
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (pc_q !== 32'h0) begin errors++; $display("FAIL ar_pc_q got %h exp %h", pc_q, 32'h0); end
    checks++; if (pc_prev !== 32'h0) begin errors++; $display("FAIL ar_pc_prev got %h exp %h", pc_prev, 32'h0); end
    checks++; if ({update, sel_err, align_err} !== 3'b000) begin errors++; $display("FAIL ar_flags got %b exp 000", {update, sel_err, align_err}); end
    step();
    checks++; if (pc_q !== 32'h0) begin errors++; $display("FAIL ar_load_ignored got %h exp %h", pc_q, 32'h0); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL ar_flag_ignored got %b exp 0", sel_err); end
    sel = 3'd0;
    src[0*W +: W] = 32'h4;
    reset_n = 1'b1;
    step();
    idle();
    checks++; if (pc_q !== 32'h4) begin errors++; $display("FAIL ar_first_load got %h exp %h", pc_q, 32'h4); end
    checks++; if (pc_prev !== 32'h0) begin errors++; $display("FAIL ar_first_prev got %h exp %h", pc_prev, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_branch();
    test_back_to_back();
    test_illegal_sel();
    test_flag_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
